// File: rtl/time_preset_entry.sv
// Key-driven BCD time entry with a sequential Horner converter that turns the
// edited digits into a binary millisecond preset offered on a valid/ready handshake.
module time_preset_entry #(
    parameter int DIGITS = 6,
    parameter int W      = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_digit,
    input  logic                key_inc,
    input  logic                key_clr,
    input  logic                key_commit,
    input  logic                preset_ready,
    output logic [4*DIGITS-1:0] digits,
    output logic [2:0]          cursor,
    output logic                busy,
    output logic [W-1:0]        preset,
    output logic                preset_valid
);

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [4*DIGITS-1:0] digits_reg, digits_next;
    logic [2:0]          cursor_reg, cursor_next;
    logic [2:0]          idx_reg, idx_next;
    logic [W-1:0]        acc_reg, acc_next;
    logic [W-1:0]        preset_reg, preset_next;
    logic                valid_reg, valid_next;

    logic       editing;
    logic       do_clr, do_commit, do_inc, do_digit;
    logic [3:0] conv_digit;
    logic [W-1:0] acc_mac;

    // One key action per cycle, strict priority clr > commit > inc > digit.
    assign editing   = (state_reg == EDIT);
    assign do_clr    = editing & key_clr;
    assign do_commit = editing & ~key_clr & key_commit;
    assign do_inc    = editing & ~key_clr & ~key_commit & key_inc;
    assign do_digit  = editing & ~key_clr & ~key_commit & ~key_inc & key_digit;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            logic       sel;
            assign cur = digits_reg[4*gi +: 4];
            assign sel = (cursor_reg == 3'(gi));
            assign digits_next[4*gi +: 4] =
                do_clr          ? 4'd0 :
                (do_inc && sel) ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1) :
                                  cur;
        end
    endgenerate

    always_comb begin
        conv_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == 3'(i)) begin
                conv_digit = digits_reg[4*i +: 4];
            end
        end
    end

    // acc*10 + digit; W is sized so the full DIGITS-digit value never overflows.
    assign acc_mac = (acc_reg << 3) + (acc_reg << 1) + {{(W-4){1'b0}}, conv_digit};

    always_comb begin
        state_next  = state_reg;
        cursor_next = cursor_reg;
        idx_next    = idx_reg;
        acc_next    = acc_reg;
        preset_next = preset_reg;
        valid_next  = valid_reg;
        case (state_reg)
            EDIT: begin
                if (do_commit) begin
                    acc_next   = '0;
                    idx_next   = 3'(DIGITS - 1);
                    state_next = CONV;
                end else if (do_digit) begin
                    cursor_next = (cursor_reg == 3'(DIGITS - 1)) ? 3'd0 : cursor_reg + 3'd1;
                end
            end
            CONV: begin
                acc_next = acc_mac;
                if (idx_reg == 3'd0) begin
                    preset_next = acc_mac;
                    valid_next  = 1'b1;
                    state_next  = HOLD;
                end else begin
                    idx_next = idx_reg - 3'd1;
                end
            end
            HOLD: begin
                if (valid_reg && preset_ready) begin
                    valid_next = 1'b0;
                    state_next = EDIT;
                end
            end
            default: begin
                state_next = EDIT;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= EDIT;
            digits_reg <= '0;
            cursor_reg <= 3'd0;
            idx_reg    <= 3'd0;
            acc_reg    <= '0;
            preset_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            digits_reg <= digits_next;
            cursor_reg <= cursor_next;
            idx_reg    <= idx_next;
            acc_reg    <= acc_next;
            preset_reg <= preset_next;
            valid_reg  <= valid_next;
        end
    end

    assign digits       = digits_reg;
    assign cursor       = cursor_reg;
    assign busy         = (state_reg != EDIT);
    assign preset       = preset_reg;
    assign preset_valid = valid_reg;

endmodule

// File: tb/tb_time_preset_entry.sv
// Directed plus randomized bench for time_preset_entry, checked against a
// decimal-arithmetic model of the entry panel.
module tb_time_preset_entry;

    localparam int DIGITS = 6;
    localparam int W      = 20;

    logic                clk;
    logic                rst_n;
    logic                key_digit, key_inc, key_clr, key_commit;
    logic                preset_ready;
    logic [4*DIGITS-1:0] digits;
    logic [2:0]          cursor;
    logic                busy;
    logic [W-1:0]        preset;
    logic                preset_valid;

    time_preset_entry #(.DIGITS(DIGITS), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_digit    (key_digit),
        .key_inc      (key_inc),
        .key_clr      (key_clr),
        .key_commit   (key_commit),
        .preset_ready (preset_ready),
        .digits       (digits),
        .cursor       (cursor),
        .busy         (busy),
        .preset       (preset),
        .preset_valid (preset_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: the digits as plain decimal numbers and the cursor position.
    int m_dig[DIGITS];
    int m_cur;
    int m_preset;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] exp_digits();
        logic [4*DIGITS-1:0] d;
        for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'(m_dig[i]);
        return d;
    endfunction

    function automatic int model_value();
        int v = 0;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v += m_dig[i] * p;
            p *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
        m_cur    = 0;
        m_preset = 0;
    endtask

    task automatic clear_keys();
        key_clr = 0; key_commit = 0; key_inc = 0; key_digit = 0;
    endtask

    // One edit-mode cycle with the given keys; the model applies the highest-priority key.
    task automatic press(input bit clr, input bit commit, input bit inc, input bit dig);
        @(negedge clk);
        key_clr = clr; key_commit = commit; key_inc = inc; key_digit = dig;
        @(posedge clk);
        #1;
        clear_keys();
        if (clr) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
        end else if (commit) begin
            // digits frozen, conversion starts
        end else if (inc) begin
            m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
        end else if (dig) begin
            m_cur = (m_cur + 1) % DIGITS;
        end
        chk("digits", 32'(digits), 32'(exp_digits()));
        chk("cursor", 32'(cursor), 32'(m_cur));
        chk("busy_edit", 32'(busy), 32'(commit && !clr));
    endtask

    task automatic set_value(input int v);
        int t[DIGITS];
        int r = v;
        for (int i = 0; i < DIGITS; i++) begin
            t[i] = r % 10;
            r /= 10;
        end
        for (int i = 0; i < DIGITS; i++) begin
            while (m_cur != i) press(0, 0, 0, 1);
            while (m_dig[i] != t[i]) press(0, 0, 1, 0);
        end
    endtask

    // Commit, wait for valid with a bounded count, then complete the handshake.
    task automatic commit_and_check(input bit ready_hold, input bit noise, input int hold_cycles);
        int  exp_val;
        int  n;
        bit  seen;
        exp_val = model_value();
        preset_ready = ready_hold;
        press(0, 1, 0, 0);
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (noise) {key_clr, key_commit, key_inc, key_digit} = 4'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (preset_valid) seen = 1;
            else chk("busy_conv", 32'(busy), 32'd1);
        end
        clear_keys();
        chk("valid_rise", 32'(seen), 32'd1);
        chk("latency", 32'(n), 32'(DIGITS));
        chk("preset", 32'(preset), 32'(exp_val));
        if (ready_hold) begin
            @(posedge clk);
            #1;
            chk("valid_one_cycle", 32'(preset_valid), 32'd0);
        end else begin
            for (int c = 0; c < hold_cycles; c++) begin
                @(negedge clk);
                if (noise) {key_clr, key_commit, key_inc, key_digit} = 4'($urandom);
                @(posedge clk);
                #1;
                if (c % 5 == 0) begin
                    chk("hold_valid", 32'(preset_valid), 32'd1);
                    chk("hold_preset", 32'(preset), 32'(exp_val));
                end
            end
            @(negedge clk);
            clear_keys();
            preset_ready = 1;
            @(posedge clk);
            #1;
            chk("valid_fall", 32'(preset_valid), 32'd0);
        end
        clear_keys();
        preset_ready = 0;
        m_preset = exp_val;
        chk("busy_after", 32'(busy), 32'd0);
        chk("preset_kept", 32'(preset), 32'(m_preset));
        chk("digits_kept", 32'(digits), 32'(exp_digits()));
        chk("cursor_kept", 32'(cursor), 32'(m_cur));
        $display("xfer preset=%0d (expected %0d) digits=%h", preset, exp_val, digits);
    endtask

    initial begin
        rst_n = 0;
        preset_ready = 0;
        clear_keys();
        model_reset();
        #23;
        @(negedge clk);
        rst_n = 1;

        // Reset state after idling
        repeat (10) @(posedge clk);
        #1;
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(preset_valid), 32'd0);
        chk("rst_preset", 32'(preset), 32'd0);

        // 3 increments, move cursor, 12 increments -> 23
        repeat (3) press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        repeat (12) press(0, 0, 1, 0);
        chk("val23", 32'(digits), 32'h23);
        commit_and_check(0, 0, 20);

        // Asynchronous reset in the middle of a conversion
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("arst_digits", 32'(digits), 32'd0);
        chk("arst_cursor", 32'(cursor), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(preset_valid), 32'd0);
        chk("arst_preset", 32'(preset), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_stays_idle", 32'(preset_valid), 32'd0);

        // All nines, cursor wraps through every digit
        for (int i = 0; i < DIGITS; i++) begin
            repeat (9) press(0, 0, 1, 0);
            press(0, 0, 0, 1);
        end
        chk("cursor_wrap", 32'(cursor), 32'd0);
        commit_and_check(0, 0, 3);

        // Cursor wrap and key priority
        repeat (7) press(0, 0, 0, 1);
        press(0, 0, 1, 1);
        press(1, 1, 0, 0);
        chk("clr_over_commit", 32'(busy), 32'd0);

        // Keys pressed during CONV and HOLD are ignored
        set_value(407163);
        commit_and_check(0, 1, 10);

        // Ready held high: single-cycle valid, then back-to-back commit
        press(1, 0, 0, 0);
        set_value(59000);
        commit_and_check(1, 0, 0);
        commit_and_check(1, 0, 0);

        // Randomized editing rounds
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 40; k++) begin
                logic [31:0] rv;
                rv = $urandom;
                press(rv[7:0] == 8'd0, 0, rv[9], rv[10]);
            end
            commit_and_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/time_preset_entry.md
Name: time_preset_entry

Overview:
- User-side time entry for the stopwatch/timer datapath.
- Runs in the opposite direction to the binary-to-BCD display path: debounced key pulses edit a set of BCD digits, then a sequential Horner converter turns those digits into a binary millisecond count.
- The count is offered to the timer on a valid/ready handshake.
- The digit bus and cursor drive seg7 control while editing.

Parameters:
- DIGITS, 6, number of BCD digits edited; legal range 4..6. Digit 0 is least significant, in ms.
- W, 20, width of the binary preset. Must satisfy 2^W > 10^DIGITS - 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_digit  in  1  debounced one-cycle pulse; advance the cursor.
- key_inc  in  1  debounced one-cycle pulse; increment the digit under the cursor.
- key_clr  in  1  debounced one-cycle pulse; zero all digits.
- key_commit  in  1  debounced one-cycle pulse; start conversion.
- preset_ready  in  1  timer accepts the preset.
- digits  out  4*DIGITS  BCD digits; digit i is at [4i+3:4i].
- cursor  out  3  index of the selected digit.
- busy  out  1  high in CONV and HOLD.
- preset  out  W  binary value in ms.
- preset_valid  out  1  preset is offered.

Behaviour:
- Reset (async, rst_n=0): digits=0, cursor=0, state=EDIT, preset=0, preset_valid=0, busy=0, internal acc=0, idx=0. A reset mid-conversion or mid-HOLD aborts immediately; there is no pending output after reset.
- States:
  - EDIT: keys are active.
  - CONV: conversion in progress.
  - HOLD: preset is offered. busy = (state != EDIT).
- EDIT, one key action per cycle. Priority is key_clr > key_commit > key_inc > key_digit; lower-priority pulses in the same cycle are dropped.
  - key_clr: all digits <= 0; cursor unchanged.
  - key_commit: acc <= 0, idx <= DIGITS-1, state <= CONV. Digits are frozen from this edge.
  - key_inc: digit[cursor] <= digit+1, wrapping 9 -> 0.
  - key_digit: cursor <= cursor+1, wrapping DIGITS-1 -> 0.
- CONV, each edge:
  - acc <= acc*10 + digit[idx], where acc*10 = (acc<<3)+(acc<<1), computed in W bits with no overflow by construction.
  - If idx==0: preset <= that result, preset_valid <= 1, state <= HOLD. Otherwise idx <= idx-1.
  - Latency: preset_valid rises exactly DIGITS edges after the commit edge.
  - All keys are ignored in CONV.
- HOLD:
  - preset and preset_valid stay stable until the handshake.
  - On an edge with preset_valid & preset_ready: preset_valid <= 0, state <= EDIT.
  - preset retains its value after the handshake; digits and cursor are retained so the user can re-edit.
  - All keys are ignored in HOLD.
  - If preset_ready is already high when preset_valid rises, the transfer completes on the next edge, so valid is high for exactly 1 cycle.
- preset_ready is ignored outside HOLD.
- Digits are never outside 0..9, and cursor is never >= DIGITS, from any reachable state.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset then idle 10 cycles -> digits=0, cursor=0, busy=0, preset_valid=0. Assert rst_n=0 mid-CONV -> all outputs back to reset values asynchronously, before the next clk edge.
2. From reset, pulse key_inc 3x, key_digit 1x, key_inc 12x, then key_commit; hold preset_ready=0:
   - digit0=3, digit1=2 (12 mod 10).
   - busy=1 on the edge after commit.
   - preset_valid rises exactly 6 edges after the commit edge with preset=23.
   - preset stays 23 with valid high for 20 cycles.
   - Raise preset_ready -> valid falls on the next edge, busy=0, digits still 23.
3. Enter digits 9,9,9,9,9,9 (wrap the cursor through all 6 digits) and commit -> preset=999999 (0xF423F); no truncation.
4. Press key_digit 7x from cursor 0 -> cursor=1. Assert key_inc with key_digit in the same cycle -> only the increment happens, cursor unchanged. Assert key_clr with key_commit -> digits=0, state stays EDIT.
5. During CONV and during HOLD, pulse every key -> digits, cursor and preset unchanged; the conversion result equals the value frozen at commit.
6. Hold preset_ready=1 constantly and commit 59000 (digits 0,5,9,0,0,0) -> preset_valid high for exactly 1 cycle with preset=59000. A second commit immediately after returns preset=59000 again.
